// File: rtl/quadra_feeder.sv
// quadra_feeder: sweep sequencer that feeds x samples to the quadratic pipeline and counts returned results
// Ports: clk/rst (sync, active-high); cmd_*_i sweep command with cmd_valid_i/cmd_ready_o handshake;
//        x_o/x_dv_o samples to the pipeline; y_dv_i result strobes back; busy_o, done_o pulse, err_spurious_o sticky.
module quadra_feeder #(
  parameter int X_W   = 24,
  parameter int CNT_W = 16,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [X_W-1:0]   cmd_start_i,
  input  logic [X_W-1:0]   cmd_step_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic [GAP_W-1:0] cmd_gap_i,
  output logic [X_W-1:0]   x_o,
  output logic             x_dv_o,
  input  logic             y_dv_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_spurious_o
);
  typedef enum logic [1:0] {IDLE, EMIT, GAP, DRAIN} state_t;
  state_t state_q, state_d;
  logic [X_W-1:0] x_q, x_d, value_q, value_d, step_q, step_d, v_src, s_src;
  logic [CNT_W-1:0] rem_q, rem_d, out_q, out_d, r_src;
  logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
  logic x_dv_q, done_q, done_d, err_q, err_d, accept, spur, adv;
  assign cmd_ready_o = state_q == IDLE && !rst;
  assign busy_o = state_q != IDLE;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign x_o = x_q;
  assign x_dv_o = x_dv_q;
  assign done_o = done_q;
  assign err_spurious_o = err_q;
  // The first sample of a sweep comes straight from the command, later ones from the latched running value.
  assign v_src = state_q == IDLE ? cmd_start_i : value_q;
  assign s_src = state_q == IDLE ? cmd_step_i : step_q;
  assign r_src = state_q == IDLE ? cmd_count_i : rem_q;
  assign spur = y_dv_i && !x_dv_q && out_q == '0;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    value_d = value_q;
    step_d = step_q;
    rem_d = rem_q;
    gap_d = gap_q;
    gcnt_d = gcnt_q;
    done_d = 1'b0;
    adv = 1'b0;
    out_d = (x_dv_q && !y_dv_i) ? out_q + 1'b1 : (y_dv_i && !x_dv_q && !spur) ? out_q - 1'b1 : out_q;
    err_d = (err_q && !accept) || spur;
    case (state_q)
      IDLE: if (accept) begin
        step_d = cmd_step_i;
        gap_d = cmd_gap_i;
        adv = cmd_count_i != '0;
        state_d = adv ? EMIT : DRAIN;
      end
      EMIT: if (rem_q == '0) state_d = DRAIN;
        else if (gap_q != '0) begin
          state_d = GAP;
          gcnt_d = gap_q;
        end else adv = 1'b1;
      GAP: begin
        gcnt_d = gcnt_q - 1'b1;
        adv = gcnt_q == GAP_W'(1);
        state_d = adv ? EMIT : GAP;
      end
      DRAIN: if (out_d == '0) begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // rem counts samples still to emit after the one being launched now.
    if (adv) begin
      x_d = v_src;
      value_d = v_src + s_src;
      rem_d = r_src - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      x_dv_q <= 1'b0;
      value_q <= '0;
      step_q <= '0;
      rem_q <= '0;
      out_q <= '0;
      gap_q <= '0;
      gcnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      x_dv_q <= adv;
      value_q <= value_d;
      step_q <= step_d;
      rem_q <= rem_d;
      out_q <= out_d;
      gap_q <= gap_d;
      gcnt_q <= gcnt_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_quadra_feeder.sv
// tb_quadra_feeder: scoreboard bench for quadra_feeder with a 3-cycle y_dv loopback
module tb_quadra_feeder;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, y_force = 1'b0;
  logic [23:0] cmd_start = '0, cmd_step = '0, hold = '0;
  logic [15:0] cmd_count = '0;
  logic [3:0] cmd_gap = '0;
  logic [2:0] ydl = '0;
  logic cmd_ready_o, x_dv_o, busy_o, done_o, err_spurious_o;
  logic [23:0] x_o;
  typedef struct {logic [23:0] v; int c;} xe_t;
  xe_t xq[$];
  xe_t me;
  int dq[$];
  logic [23:0] ev[$];
  int cyc = 0, n_chk = 0, n_pass = 0, md;
  quadra_feeder dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_start_i(cmd_start), .cmd_step_i(cmd_step), .cmd_count_i(cmd_count), .cmd_gap_i(cmd_gap),
    .x_o(x_o), .x_dv_o(x_dv_o), .y_dv_i(ydl[2] | y_force), .busy_o(busy_o), .done_o(done_o),
    .err_spurious_o(err_spurious_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Stand-in for the 3-stage pipeline: each x_dv comes back as y_dv three cycles later.
  always @(posedge clk) ydl <= rst ? 3'b000 : {ydl[1:0], x_dv_o};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask
  task automatic bad(input string nm, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %0h, nothing expected", nm, act);
  endtask
  always @(negedge clk) begin
    if (x_dv_o) begin
      if (xq.size() == 0) bad("unexpected x_dv, x", {8'h0, x_o});
      else begin
        me = xq.pop_front();
        chk("x value", {8'h0, x_o}, {8'h0, me.v});
        chk("x_dv cycle", cyc, me.c);
        hold = me.v;
      end
    end else if (busy_o) chk("x hold while idle", {8'h0, x_o}, {8'h0, hold});
    if (done_o) begin
      if (dq.size() == 0) bad("unexpected done at cycle", cyc);
      else begin
        md = dq.pop_front();
        chk("done cycle", cyc, md);
      end
    end
  end
  task automatic send(input logic [23:0] s, input logic [23:0] st, input logic [15:0] n, input logic [3:0] g);
    int t;
    xe_t e;
    @(negedge clk);
    chk("cmd_ready before command", {31'h0, cmd_ready_o}, 1);
    cmd_valid = 1'b1;
    cmd_start = s;
    cmd_step = st;
    cmd_count = n;
    cmd_gap = g;
    t = cyc;
    for (int k = 0; k < int'(n); k++) begin
      e.v = ev[k];
      e.c = t + 1 + k * (int'(g) + 1);
      xq.push_back(e);
    end
    dq.push_back(n == 0 ? t + 2 : t + 1 + (int'(n) - 1) * (int'(g) + 1) + 4);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic wait_drain();
    int k = 0;
    while ((xq.size() != 0 || dq.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pending expectations after drain", xq.size() + dq.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("reset x", {8'h0, x_o}, 0);
    chk("reset x_dv", {31'h0, x_dv_o}, 0);
    chk("reset done", {31'h0, done_o}, 0);
    chk("reset err", {31'h0, err_spurious_o}, 0);
    chk("reset busy", {31'h0, busy_o}, 0);
    chk("cmd_ready in reset", {31'h0, cmd_ready_o}, 0);
    rst = 1'b0;
    #1 chk("cmd_ready after reset", {31'h0, cmd_ready_o}, 1);
    ev.delete(); ev.push_back(24'd5); ev.push_back(24'd8); ev.push_back(24'd11); ev.push_back(24'd14);
    send(24'd5, 24'd3, 16'd4, 4'd0);
    wait_drain();
    chk("err after basic", {31'h0, err_spurious_o}, 0);
    ev.delete(); ev.push_back(24'hFFFFFE); ev.push_back(24'hFFFFFF); ev.push_back(24'h000000);
    send(24'hFFFFFE, 24'd1, 16'd3, 4'd2);
    wait_drain();
    ev.delete();
    send(24'h123, 24'd1, 16'd0, 4'd0);
    @(negedge clk);
    chk("busy zero-count T+1", {31'h0, busy_o}, 1);
    chk("x_dv zero-count", {31'h0, x_dv_o}, 0);
    @(negedge clk);
    chk("busy zero-count T+2", {31'h0, busy_o}, 0);
    chk("cmd_ready with done", {31'h0, cmd_ready_o}, 1);
    wait_drain();
    @(negedge clk);
    y_force = 1'b1;
    @(negedge clk);
    y_force = 1'b0;
    chk("err after spurious", {31'h0, err_spurious_o}, 1);
    repeat (3) @(negedge clk);
    chk("err sticky", {31'h0, err_spurious_o}, 1);
    ev.delete(); ev.push_back(24'd7);
    send(24'd7, 24'd0, 16'd1, 4'd0);
    @(negedge clk);
    chk("err cleared by command", {31'h0, err_spurious_o}, 0);
    wait_drain();
    ev.delete(); ev.push_back(24'd3); ev.push_back(24'd2); ev.push_back(24'd1);
    ev.push_back(24'd0); ev.push_back(24'hFFFFFF); ev.push_back(24'hFFFFFE);
    send(24'd3, 24'hFFFFFF, 16'd6, 4'd0);
    @(negedge clk);
    chk("busy during sweep", {31'h0, busy_o}, 1);
    chk("cmd_ready during sweep", {31'h0, cmd_ready_o}, 0);
    cmd_valid = 1'b1;
    cmd_start = 24'h55;
    cmd_count = 16'd2;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);
    chk("err after overlap sweep", {31'h0, err_spurious_o}, 0);
    send(24'd3, 24'hFFFFFF, 16'd6, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    xq.delete();
    dq.delete();
    hold = '0;
    @(negedge clk);
    chk("mid reset x", {8'h0, x_o}, 0);
    chk("mid reset x_dv", {31'h0, x_dv_o}, 0);
    chk("mid reset done", {31'h0, done_o}, 0);
    chk("mid reset busy", {31'h0, busy_o}, 0);
    chk("mid reset cmd_ready", {31'h0, cmd_ready_o}, 0);
    rst = 1'b0;
    #1 chk("cmd_ready after mid reset", {31'h0, cmd_ready_o}, 1);
    repeat (12) @(negedge clk);
    chk("err after mid reset", {31'h0, err_spurious_o}, 0);
    ev.delete(); ev.push_back(24'd9); ev.push_back(24'd10);
    send(24'd9, 24'd1, 16'd2, 4'd1);
    wait_drain();
    chk("err after restart", {31'h0, err_spurious_o}, 0);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
